// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio
// Description : Data-memory responder for the core's load/store port. Provides
//               byte-lane RAM plus a GPIO / compare-timer / interrupt window.
//               Timer logic is present only when DMEM_TIMER_EN is defined.
// Revision    : 1.0
// ============================================================================
module dmem_mmio #(
    parameter int          RAM_ADDR_W = 10,
    parameter logic [15:0] MMIO_BASE  = 16'h1FD0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic [7:0]  gpio_i,
    output logic [7:0]  gpio_o,
    output logic [5:0]  int_o
);

    localparam int         c_ram_depth    = 1 << RAM_ADDR_W;
    localparam logic [2:0] c_off_gpio_out = 3'd0;
    localparam logic [2:0] c_off_gpio_in  = 3'd1;
    localparam logic [2:0] c_off_tmr_cnt  = 3'd2;
    localparam logic [2:0] c_off_tmr_cmp  = 3'd3;
    localparam logic [2:0] c_off_tmr_ctrl = 3'd4;
    localparam logic [2:0] c_off_int_stat = 3'd5;
    localparam logic [2:0] c_off_int_mask = 3'd6;

    logic                  w_is_mmio;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_reg_wr;
    logic [2:0]            w_off;
    logic [RAM_ADDR_W-1:0] w_ram_idx;
    logic [31:0]           w_ram_rd;
    logic [31:0]           w_reg_rd;
    logic                  w_match;
    logic                  w_edge;
    logic [1:0]            w_stat_clr;
    logic [1:0]            w_stat_set;
    logic [31:0]           w_tmr_cnt_rd;
    logic [31:0]           w_tmr_cmp_rd;
    logic [31:0]           w_tmr_ctrl_rd;
    logic                  w_unused;

    logic [7:0]            r_gpio_out;
    logic [7:0]            r_sync1;
    logic [7:0]            r_sync2;
    logic                  r_prev;
    logic [1:0]            r_int_stat;
    logic [1:0]            r_int_mask;

    assign w_is_mmio = (addr_i[31:16] == MMIO_BASE);
    assign w_wr      = ce_i & we_i;
    assign w_rd      = ce_i & ~we_i & ~rst;
    assign w_off     = addr_i[4:2];
    assign w_ram_idx = addr_i[RAM_ADDR_W+1:2];
    // Register writes require a full-word store; partial stores are dropped.
    assign w_reg_wr  = w_wr & w_is_mmio & (sel_i == 4'b1111);
    // Low byte-offset bits and the aliased upper address bits are don't-care.
    assign w_unused  = ^addr_i;

    // One byte-wide bank per lane so each lane write enable stays independent.
    for (genvar n = 0; n < 4; n++) begin : g_lane
        logic [7:0] r_bank [c_ram_depth];

        always_ff @(posedge clk) begin : p_bank_wr
            if (w_wr && !w_is_mmio && sel_i[n]) begin
                r_bank[w_ram_idx] <= data_i[8*n +: 8];
            end
        end

        assign w_ram_rd[8*n +: 8] = r_bank[w_ram_idx];
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] r_tmr_cnt;
    logic [31:0] r_tmr_cmp;
    logic [2:0]  r_tmr_ctrl;

    // Match looks at the counter value before any same-cycle software write.
    assign w_match       = r_tmr_ctrl[0] && (r_tmr_cnt == r_tmr_cmp);
    assign w_tmr_cnt_rd  = r_tmr_cnt;
    assign w_tmr_cmp_rd  = r_tmr_cmp;
    assign w_tmr_ctrl_rd = {29'h0, r_tmr_ctrl};

    always_ff @(posedge clk or posedge rst) begin : p_timer
        if (rst) begin
            r_tmr_cnt  <= '0;
            r_tmr_cmp  <= '0;
            r_tmr_ctrl <= '0;
        end else begin
            if (w_reg_wr && w_off == c_off_tmr_cnt) begin
                r_tmr_cnt <= data_i;
            end else if (r_tmr_ctrl[0]) begin
                r_tmr_cnt <= (w_match && r_tmr_ctrl[1]) ? 32'h0 : r_tmr_cnt + 32'h1;
            end
            if (w_reg_wr && w_off == c_off_tmr_cmp) begin
                r_tmr_cmp <= data_i;
            end
            if (w_reg_wr && w_off == c_off_tmr_ctrl) begin
                r_tmr_ctrl <= data_i[2:0];
            end
        end
    end
`else
    assign w_match       = 1'b0;
    assign w_tmr_cnt_rd  = '0;
    assign w_tmr_cmp_rd  = '0;
    assign w_tmr_ctrl_rd = '0;
`endif

    assign w_edge     = r_sync2[0] & ~r_prev;
    assign w_stat_set = {w_edge, w_match};
    assign w_stat_clr = (w_reg_wr && w_off == c_off_int_stat) ? data_i[1:0] : 2'b00;

    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= 1'b0;
            r_int_stat <= '0;
            r_int_mask <= '0;
        end else begin
            r_sync1 <= gpio_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2[0];
            if (w_reg_wr && w_off == c_off_gpio_out) begin
                r_gpio_out <= data_i[7:0];
            end
            if (w_reg_wr && w_off == c_off_int_mask) begin
                r_int_mask <= data_i[1:0];
            end
            // Hardware set is OR-ed in after the clear so it wins a collision.
            r_int_stat <= (r_int_stat & ~w_stat_clr) | w_stat_set;
        end
    end

    always_comb begin : p_reg_rd
        w_reg_rd = '0;
        case (w_off)
            c_off_gpio_out: w_reg_rd = {24'h0, r_gpio_out};
            c_off_gpio_in:  w_reg_rd = {24'h0, r_sync2};
            c_off_tmr_cnt:  w_reg_rd = w_tmr_cnt_rd;
            c_off_tmr_cmp:  w_reg_rd = w_tmr_cmp_rd;
            c_off_tmr_ctrl: w_reg_rd = w_tmr_ctrl_rd;
            c_off_int_stat: w_reg_rd = {30'h0, r_int_stat};
            c_off_int_mask: w_reg_rd = {30'h0, r_int_mask};
            default:        w_reg_rd = '0;
        endcase
    end

    assign data_o = w_rd ? (w_is_mmio ? w_reg_rd : w_ram_rd) : 32'h0;
    assign gpio_o = r_gpio_out;
    assign int_o  = {4'b0000, r_int_stat & r_int_mask};

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_mmio
// Description : Self-checking bench for dmem_mmio against a transaction-level
//               reference model (directed scenarios, then random traffic).
// Revision    : 1.0
// ============================================================================
module tb_dmem_mmio;

    localparam int          RAM_ADDR_W = 10;
    localparam logic [15:0] MMIO_BASE  = 16'h1FD0;
`ifdef DMEM_TIMER_EN
    localparam bit c_timer = 1'b1;
`else
    localparam bit c_timer = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdata = '0;
    logic [7:0]  gpio = '0;
    logic [31:0] data_o;
    logic [7:0]  gpio_o;
    logic [5:0]  int_o;

    dmem_mmio #(.RAM_ADDR_W(RAM_ADDR_W), .MMIO_BASE(MMIO_BASE)) u_dut (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .data_o(data_o), .gpio_i(gpio), .gpio_o(gpio_o), .int_o(int_o)
    );

    always #5 clk = ~clk;

    // Reference model state: RAM keyed by word index, registers by name.
    logic [31:0] m_ram [int];
    logic [7:0]  m_gpio_out;
    logic [7:0]  m_pipe [2];
    logic        m_prev;
    logic [31:0] m_cnt, m_cmp;
    logic [2:0]  m_ctrl;
    logic [1:0]  m_stat, m_mask;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mmio_addr(input int off);
        return {MMIO_BASE, 16'h0} + 32'(off * 4);
    endfunction

    function automatic int word_index(input logic [31:0] a);
        return int'((a >> 2) % (32'h1 << RAM_ADDR_W));
    endfunction

    task automatic model_reset();
        m_gpio_out = '0; m_pipe[0] = '0; m_pipe[1] = '0; m_prev = 1'b0;
        m_cnt = '0; m_cmp = '0; m_ctrl = '0; m_stat = '0; m_mask = '0;
    endtask

    function automatic logic [31:0] m_read();
        int reg_no;
        int idx;
        if (rst || !ce || we) return 32'h0;
        if (addr[31:16] == MMIO_BASE) begin
            reg_no = int'((addr % 32) / 4);
            case (reg_no)
                0: return {24'h0, m_gpio_out};
                1: return {24'h0, m_pipe[1]};
                2: return m_cnt;
                3: return m_cmp;
                4: return {29'h0, m_ctrl};
                5: return {30'h0, m_stat};
                6: return {30'h0, m_mask};
                default: return 32'h0;
            endcase
        end
        idx = word_index(addr);
        return m_ram.exists(idx) ? m_ram[idx] : 32'hxxxx_xxxx;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit          mmio, full, match, rise;
        int          reg_no, idx;
        logic [1:0]  clr;
        logic [31:0] word;
        mmio   = (addr[31:16] == MMIO_BASE);
        full   = ce && we && mmio && (sel == 4'hF);
        reg_no = int'((addr % 32) / 4);
        match  = c_timer && m_ctrl[0] && (m_cnt == m_cmp);
        rise   = m_pipe[1][0] && !m_prev;
        clr    = (full && reg_no == 5) ? wdata[1:0] : 2'b00;
        if (c_timer && full && reg_no == 2) m_cnt = wdata;
        else if (c_timer && m_ctrl[0]) m_cnt = (match && m_ctrl[1]) ? 32'h0 : m_cnt + 32'h1;
        if (c_timer && full && reg_no == 3) m_cmp = wdata;
        if (c_timer && full && reg_no == 4) m_ctrl = wdata[2:0];
        if (full && reg_no == 0) m_gpio_out = wdata[7:0];
        if (full && reg_no == 6) m_mask = wdata[1:0];
        m_stat = (m_stat & ~clr) | {rise, match};
        m_prev = m_pipe[1][0];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = gpio;
        if (ce && we && !mmio) begin
            idx  = word_index(addr);
            word = m_ram.exists(idx) ? m_ram[idx] : 32'hxxxx_xxxx;
            for (int n = 0; n < 4; n++) if (sel[n]) word[8*n +: 8] = wdata[8*n +: 8];
            m_ram[idx] = word;
        end
    endtask

    // Drive one request, check outputs mid-cycle, then step the model at the edge.
    task automatic apply(input bit c, input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input string tag);
        ce = c; we = w; addr = a; sel = s; wdata = d;
        @(negedge clk);
        check({tag, " data_o"}, data_o, m_read());
        check({tag, " gpio_o"}, {24'h0, gpio_o}, {24'h0, m_gpio_out});
        check({tag, " int_o"}, {26'h0, int_o}, {30'h0, m_stat & m_mask});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr_reg(input int off, input logic [31:0] d);
        apply(1'b1, 1'b1, mmio_addr(off), 4'hF, d, "reg wr");
    endtask

    task automatic rd_reg(input int off);
        apply(1'b1, 1'b0, mmio_addr(off), 4'h0, 32'h0, "reg rd");
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        model_reset();
        ce = 1'b1; addr = mmio_addr(0);
        #2;
        check("reset data_o", data_o, 32'h0);
        check("reset gpio_o", {24'h0, gpio_o}, 32'h0);
        check("reset int_o", {26'h0, int_o}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;

        // Byte-lane writes and read gating
        apply(1'b1, 1'b1, 32'h100, 4'hF, 32'hAABB_CCDD, "lane wr");
        apply(1'b1, 1'b1, 32'h100, 4'b0101, 32'h1122_3344, "lane wr part");
        apply(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, "lane rd");
        check("lane merge", data_o, 32'hAA22_CC44);
        apply(1'b0, 1'b0, 32'h100, 4'hF, 32'h0, "ce0 rd");
        check("ce0 zero", data_o, 32'h0);
        apply(1'b1, 1'b1, 32'h100, 4'h0, 32'h0, "we1 no-lane");

        // Address aliasing above the RAM index bits
        apply(1'b1, 1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF, "alias wr");
        apply(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, "alias rd");
        check("alias data", data_o, 32'hDEAD_BEEF);

        // GPIO synchroniser, edge interrupt, partial-write rejection
        wr_reg(6, 32'h2);
        gpio = 8'h01;
        rd_reg(1);
        rd_reg(1);
        rd_reg(1);
        check("gpio edge int", {26'h0, int_o}, 32'h2);
        check("gpio_in", data_o, 32'h1);
        wr_reg(0, 32'h5A);
        apply(1'b1, 1'b1, mmio_addr(0), 4'b0011, 32'hFF, "gpio part wr");
        check("gpio partial", {24'h0, gpio_o}, 32'h5A);
        wr_reg(5, 32'h2);
        rd_reg(5);

        // Timer with auto-clear and W1C of the match flag
        wr_reg(3, 32'd3);
        wr_reg(6, 32'h3);
        wr_reg(2, 32'd0);
        wr_reg(4, 32'h3);
        for (int i = 0; i < 10; i++) rd_reg(2);
        wr_reg(5, 32'h1);
        for (int i = 0; i < 6; i++) rd_reg(5);
        wr_reg(5, 32'h1);
        rd_reg(5);

        // Timer wrap with auto-clear off
        wr_reg(4, 32'h0);
        wr_reg(2, 32'hFFFF_FFFE);
        wr_reg(3, 32'h1);
        wr_reg(5, 32'h3);
        wr_reg(4, 32'h1);
        rd_reg(2);
        check("wrap cnt", data_o, c_timer ? 32'hFFFF_FFFF : 32'h0);
        for (int i = 0; i < 4; i++) rd_reg(2);
        rd_reg(5);

        // Asynchronous reset between edges
        rd_reg(0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("arst data_o", data_o, 32'h0);
        check("arst gpio_o", {24'h0, gpio_o}, 32'h0);
        check("arst int_o", {26'h0, int_o}, 32'h0);
        #1 rst = 1'b0;
        rd_reg(2);
        rd_reg(2);

        // Random traffic over a small pre-written RAM window and all registers
        for (int w = 0; w < 16; w++) apply(1'b1, 1'b1, 32'(w * 4), 4'hF, $urandom, "ram init");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) gpio = 8'($urandom);
            if ($urandom_range(0, 9) < 5) begin
                a = $urandom & 32'hFFFF_F03C;
                if (a[31:16] == MMIO_BASE) a[31:16] = 16'h0;
                apply($urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)), a, 4'($urandom),
                      $urandom, "rnd ram");
            end else begin
                a = mmio_addr($urandom_range(0, 7)) | 32'($urandom_range(0, 3));
                d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : $urandom;
                s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                apply($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), a, s, d, "rnd mmio");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_mmio.md
# dmem_mmio

Responder for the CPU core's data-memory port. It answers load/store requests (`ram_ce_o`/`ram_we_o`/`ram_addr_o`/`ram_sel_o`/`ram_data_o`) with byte-lane-addressed data RAM plus a small memory-mapped peripheral window: GPIO, a compare timer and an interrupt status/mask pair. It drives the core's `int_i` lines. Reads are combinational so the core's single-cycle MEM stage needs no wait states; all state updates occur on the clock edge.

## Interface
Parameters:
- RAM_ADDR_W, 10, RAM depth in 32-bit words (2^RAM_ADDR_W)
- MMIO_BASE, 16'h1FD0, value of addr_i[31:16] that selects the peripheral window

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous active-high reset
- ce_i  in  1  request valid (from ram_ce_o)
- we_i  in  1  1 = write, 0 = read
- addr_i  in  32  byte address
- sel_i  in  4  byte-lane enables, bit n = data[8n+7:8n]
- data_i  in  32  write data
- data_o  out  32  read data (to ram_data_i)
- gpio_i  in  8  asynchronous input pins
- gpio_o  out  8  output pins
- int_o  out  6  interrupt lines to core int_i

## Operation
- Decode: addr_i[31:16]==MMIO_BASE selects MMIO; otherwise RAM at word index addr_i[RAM_ADDR_W+1:2]. Higher bits are ignored, so RAM aliases.
- RAM write: when ce_i&we_i, each lane with sel_i[n]=1 is written from data_i. Other lanes are unchanged.
- RAM read: data_o = full word at the index. sel_i is ignored; the core extracts bytes itself.
- data_o = 0 when rst, when ce_i=0, or when we_i=1.
- MMIO register offsets (addr_i[4:2]). Writes take effect only when sel_i==4'b1111; partial writes are ignored.
  - 0x00 GPIO_OUT: RW [7:0]; drives gpio_o.
  - 0x04 GPIO_IN: RO; 2-flop-synchronized gpio_i.
  - 0x08 TMR_CNT: RW 32.
  - 0x0C TMR_CMP: RW 32.
  - 0x10 TMR_CTRL: RW [2:0] — bit0 en, bit1 auto-clear on match.
  - 0x14 INT_STAT: [1:0], write-1-to-clear — bit0 timer match, bit1 gpio_i[0] rising edge.
  - 0x18 INT_MASK: RW [1:0].
  - Offset 0x1C and unused bits read 0; writes to them are ignored.
- Timer: when en=1, each cycle TMR_CNT increments (wraps 0xFFFFFFFF→0). Match = en && TMR_CNT==TMR_CMP.
  - On match, INT_STAT[0] is set. If auto-clear=1, the next TMR_CNT is 0 instead of TMR_CNT+1.
  - When en=0, TMR_CNT holds and no match occurs.
- Edge detect: prev <= sync2; edge = sync2 & ~prev; edge sets INT_STAT[1].
- int_o[1:0] = INT_STAT & INT_MASK; int_o[5:2] = 0.
- Simultaneous events:
  - Software write to TMR_CNT beats the increment and auto-clear.
  - A hardware set beats a W1C clear of the same bit in the same cycle.
  - A match compares the pre-write TMR_CNT value.

## Timing
- Read latency 0 (combinational from addr_i); write visible to a read in the following cycle.
- Reset (async assert): GPIO_OUT, sync flops, prev, TMR_CNT, TMR_CMP, TMR_CTRL, INT_STAT and INT_MASK all go to 0. Outputs go to data_o=0, gpio_o=0, int_o=0. RAM contents are not reset.
- Reset deasserting mid-operation: the first rising edge after release is a normal operating edge.
- Timer: with CMP=N and the counter enabled from 0, CNT==N during the cycle after the Nth increment. INT_STAT[0] and int_o[0] (if masked in) rise at the following edge.
- GPIO: gpio_i[0] rises before edge k → sync2=1 after edge k+1 → INT_STAT[1] set at edge k+2.

## Configuration
- DMEM_TIMER_EN defined: timer registers and INT_STAT[0] behave as above.
- DMEM_TIMER_EN undefined: no timer logic. TMR_CNT/TMR_CMP/TMR_CTRL read 0 and ignore writes; INT_STAT[0] and int_o[0] are constant 0. The GPIO path and RAM are unaffected.

## Test plan
- RAM lanes: write 0xAABBCCDD sel=1111 to 0x100, then 0x11223344 sel=0101 → read 0x100 returns 0xAA22CC44. Read with ce_i=0 → data_o=0.
- Alias: RAM_ADDR_W=10; write 0xDEADBEEF to 0x0000_0000 → read 0x0000_1000 returns 0xDEADBEEF.
- Timer auto-clear: CMP=3, CTRL=3'b011, MASK=1 → CNT sequence 0,1,2,3,0,1…; int_o[0] rises one edge after CNT==3. W1C write of 1 to INT_STAT clears it unless a match fires the same cycle.
- Timer wrap: CNT=0xFFFFFFFE, CMP=1, en=1, auto-clear=0 → CNT goes 0xFFFFFFFF, 0, 1; INT_STAT[0] sets after CNT==1.
- GPIO: gpio_i=8'h01 asserted before edge k, MASK=2 → int_o[1] high after edge k+2; GPIO_IN reads 0x01. A partial write (sel=0011) to GPIO_OUT leaves gpio_o unchanged.
- Async reset mid-count: assert rst between edges → data_o, gpio_o and int_o read 0 immediately; TMR_CNT reads 0 after release.
